// File: rtl/oldland_mem_responder.sv
// Oldland memory bus responder: word-addressed on-chip RAM mapped at a fixed
// word-address window, answering each request with one ack or error pulse.
module oldland_mem_responder #(
  parameter int unsigned mem_words      = 4096,
  parameter logic [29:0] base_word_addr = 30'h0,
  parameter int unsigned wait_states    = 1,
  parameter bit          read_only      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_access,
  input  logic [29:0] m_addr,
  input  logic [3:0]  m_bytesel,
  input  logic        m_wr_en,
  input  logic [31:0] m_wr_val,
  output logic [31:0] m_data,
  output logic        m_ack,
  output logic        m_error,
  output logic        busy
);

  localparam int unsigned AW    = (mem_words > 1) ? $clog2(mem_words) : 1;
  localparam logic [3:0]  WS    = 4'(wait_states);
  localparam logic [29:0] WORDS = 30'(mem_words);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [3:0]    be_q;
  logic          wr_q;
  logic [31:0]   wval_q;
  logic          ack_q;
  logic          err_q;
  logic          rd_ack_q;

  logic [31:0]   mem_q [0:mem_words-1];
  logic [31:0]   rd_q;

  logic [29:0]   offset;
  logic          hit;
  logic          reject;
  logic          re;
  logic          we;
  logic [AW-1:0] ridx;

  // Wrapping subtraction makes addresses below the base land far outside the window.
  assign offset = m_addr - base_word_addr;
  assign hit    = offset < WORDS;
  assign reject = !hit || (read_only && m_wr_en);

  // The synchronous read is issued in the cycle just before RESP, so a
  // zero-wait read must use the live address rather than the latched one.
  assign re   = ((state_q == S_IDLE) && m_access && !reject && !m_wr_en && (WS == 4'd0)) ||
                ((state_q == S_WAIT) && (cnt_q == 4'd0) && !wr_q);
  assign ridx = (state_q == S_IDLE) ? offset[AW-1:0] : idx_q;
  assign we   = (state_q == S_RESP) && wr_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be_q[i]) begin
        mem_q[idx_q][8*i +: 8] <= wval_q[8*i +: 8];
      end
    end
    if (re) begin
      rd_q <= mem_q[ridx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      be_q     <= 4'd0;
      wr_q     <= 1'b0;
      wval_q   <= 32'd0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (m_access) begin
            idx_q  <= offset[AW-1:0];
            be_q   <= m_bytesel;
            wr_q   <= m_wr_en;
            wval_q <= m_wr_val;
            if (reject) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (WS == 4'd0) begin
              state_q  <= S_RESP;
              ack_q    <= 1'b1;
              rd_ack_q <= !m_wr_en;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WS - 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= S_RESP;
            ack_q    <= 1'b1;
            rd_ack_q <= !wr_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_data  = rd_ack_q ? rd_q : 32'd0;
  assign m_ack   = ack_q;
  assign m_error = err_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_oldland_mem_responder.sv
// Directed bench for oldland_mem_responder: three instances (1 wait state,
// 0 wait states, read-only) driven from a vector table plus hand sequences.
module tb_oldland_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  acc = 3'b000;
  logic [29:0] addr = 30'd0;
  logic [3:0]  be = 4'd0;
  logic        wr = 1'b0;
  logic [31:0] wval = 32'd0;
  logic [31:0] data [3];
  logic        ack  [3];
  logic        err  [3];
  logic        busy [3];

  int checks = 0;
  int failures = 0;
  int both_hi = 0;

  always #5 clk = ~clk;

  oldland_mem_responder #(.mem_words(64), .base_word_addr(30'h100), .wait_states(1), .read_only(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .m_access(acc[0]), .m_addr(addr), .m_bytesel(be), .m_wr_en(wr),
    .m_wr_val(wval), .m_data(data[0]), .m_ack(ack[0]), .m_error(err[0]), .busy(busy[0]));
  oldland_mem_responder #(.mem_words(64), .base_word_addr(30'h100), .wait_states(0), .read_only(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .m_access(acc[1]), .m_addr(addr), .m_bytesel(be), .m_wr_en(wr),
    .m_wr_val(wval), .m_data(data[1]), .m_ack(ack[1]), .m_error(err[1]), .busy(busy[1]));
  oldland_mem_responder #(.mem_words(64), .base_word_addr(30'h100), .wait_states(1), .read_only(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .m_access(acc[2]), .m_addr(addr), .m_bytesel(be), .m_wr_en(wr),
    .m_wr_val(wval), .m_data(data[2]), .m_ack(ack[2]), .m_error(err[2]), .busy(busy[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i] && err[i]) both_hi++;
    end
  end

  typedef struct {
    int          sel;
    logic [29:0] a;
    logic [3:0]  b;
    logic        w;
    logic [31:0] v;
    logic        e;
    logic [31:0] d;
  } vec_t;

  vec_t vt [19];

  function automatic int ws_of(input int s);
    return (s == 1) ? 0 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic txn(input int s, input logic [29:0] a, input logic [3:0] b, input logic w,
                     input logic [31:0] v, input logic exp_err, input logic [31:0] exp_d,
                     input string tag);
    int n;
    bit done;
    int exp_lat;
    n = 0;
    done = 1'b0;
    exp_lat = exp_err ? 1 : 1 + ws_of(s);
    addr = a; be = b; wr = w; wval = v; acc[s] = 1'b1;
    while (!done && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) check({tag, ".busy"}, {31'd0, busy[s]}, 32'd1);
      if (ack[s] || err[s]) done = 1'b1;
    end
    acc[s] = 1'b0;
    if (!done) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, ".error"}, {31'd0, err[s]}, {31'd0, exp_err});
      check({tag, ".ack"},   {31'd0, ack[s]}, {31'd0, !exp_err});
      check({tag, ".latency"}, n, exp_lat);
      check({tag, ".data"}, data[s], exp_d);
    end
    @(negedge clk);
    check({tag, ".idle_busy"}, {31'd0, busy[s]}, 32'd0);
    check({tag, ".idle_pulse"}, {30'd0, ack[s], err[s]}, 32'd0);
  endtask

  initial begin
    int n;
    int k;
    int last;

    vt[0]  = '{0, 30'h103, 4'hF,    1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{0, 30'h103, 4'hF,    1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
    vt[2]  = '{0, 30'h104, 4'hF,    1'b1, 32'h11223344, 1'b0, 32'h0};
    vt[3]  = '{0, 30'h104, 4'b0101, 1'b1, 32'hAABBCCDD, 1'b0, 32'h0};
    vt[4]  = '{0, 30'h104, 4'hF,    1'b0, 32'h0,        1'b0, 32'h11BB33DD};
    vt[5]  = '{0, 30'h13F, 4'hF,    1'b1, 32'h0BADF00D, 1'b0, 32'h0};
    vt[6]  = '{0, 30'h140, 4'hF,    1'b0, 32'h0,        1'b1, 32'h0};
    vt[7]  = '{0, 30'h0FF, 4'hF,    1'b1, 32'h12345678, 1'b1, 32'h0};
    vt[8]  = '{0, 30'h13F, 4'hF,    1'b0, 32'h0,        1'b0, 32'h0BADF00D};
    vt[9]  = '{0, 30'h100, 4'hF,    1'b1, 32'h01020304, 1'b0, 32'h0};
    vt[10] = '{0, 30'h100, 4'h0,    1'b1, 32'h55555555, 1'b0, 32'h0};
    vt[11] = '{0, 30'h100, 4'hF,    1'b0, 32'h0,        1'b0, 32'h01020304};
    vt[12] = '{0, 30'h105, 4'hF,    1'b1, 32'hA5A5A5A5, 1'b0, 32'h0};
    vt[13] = '{1, 30'h103, 4'hF,    1'b1, 32'h13579BDF, 1'b0, 32'h0};
    vt[14] = '{1, 30'h103, 4'hF,    1'b0, 32'h0,        1'b0, 32'h13579BDF};
    vt[15] = '{1, 30'h0FF, 4'hF,    1'b0, 32'h0,        1'b1, 32'h0};
    vt[16] = '{2, 30'h100, 4'hF,    1'b1, 32'h0,        1'b1, 32'h0};
    vt[17] = '{2, 30'h100, 4'hF,    1'b0, 32'h0,        1'b0, 32'hCAFEF00D};
    vt[18] = '{2, 30'h140, 4'hF,    1'b0, 32'h0,        1'b1, 32'h0};

    // Read-only instance has no write path, so its contents are seeded directly.
    u2.mem_q[0] = 32'hCAFEF00D;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_outputs%0d", i), {data[i] | {29'd0, ack[i], err[i], busy[i]}}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      txn(vt[i].sel, vt[i].a, vt[i].b, vt[i].w, vt[i].v, vt[i].e, vt[i].d, $sformatf("vec%0d", i));
    end

    // Reset arriving while a write to word 5 waits must drop it entirely.
    addr = 30'h105; be = 4'hF; wr = 1'b1; wval = 32'hFFFFFFFF; acc[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_wait.busy", {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_wait.outputs", data[0] | {29'd0, ack[0], err[0], busy[0]}, 32'd0);
    acc[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold.outputs", data[0] | {29'd0, ack[0], err[0], busy[0]}, 32'd0);
    rst_n = 1'b1;
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack[0] || err[0]) k++;
    end
    check("rst_after.no_pulse", k, 0);
    txn(0, 30'h105, 4'hF, 1'b0, 32'h0, 1'b0, 32'hA5A5A5A5, "rst_word5");

    // Cache-line refill on the zero-wait instance with m_access held high.
    for (int i = 0; i < 8; i++) begin
      txn(1, 30'h108 + 30'(i), 4'hF, 1'b1, 32'h10000000 + 32'(i * 32'h111), 1'b0, 32'h0,
          $sformatf("fill%0d", i));
    end
    addr = 30'h108; be = 4'hF; wr = 1'b0; acc[1] = 1'b1;
    n = 0; k = 0; last = 0;
    while (k < 8 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (err[1]) check($sformatf("b2b%0d.error", k), 32'd1, 32'd0);
      if (ack[1]) begin
        check($sformatf("b2b%0d.data", k), data[1], 32'h10000000 + 32'(k * 32'h111));
        check($sformatf("b2b%0d.gap", k), n - last, (k == 0) ? 1 : 2);
        last = n;
        k++;
        if (k < 8) addr = 30'h108 + 30'(k);
        else acc[1] = 1'b0;
      end
    end
    acc[1] = 1'b0;
    check("b2b.count", k, 8);

    @(negedge clk);
    check("ack_error_exclusive", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
